// File: rtl/orb_pkg.sv
// Shared ORB pipeline constants and the descriptor streamer's read-FSM state type.
// The record layout is one header word followed by the descriptor in 32-bit slices.
package orb_pkg;

  localparam int DESC_BITS     = 256;
  localparam int COORD_W       = 11;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_REC = 9;
  localparam int IDX_W         = $clog2(WORDS_PER_REC);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_REC - 1);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_HDR  = 2'd1,
    RD_BODY = 2'd2
  } rd_state_t;

endpackage

// File: rtl/desc_fifo.sv
// Flop-array FIFO of whole descriptor records; only pointers and count are reset.
// The caller guarantees pop only when non-empty and push only when a slot is free.
module desc_fifo #(
  parameter int WIDTH = 278,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/descriptor_streamer.sv
// Buffers {kp_y, kp_x, descriptor} records and streams each one as 9 x 32-bit words.
// Valid/ready: a word transfers on any rising edge where m_valid && m_ready; while
// m_valid && !m_ready the word and its first/last marks hold steady.
module descriptor_streamer
  import orb_pkg::*;
#(
  parameter int DESC_BITS = orb_pkg::DESC_BITS,
  parameter int COORD_W   = orb_pkg::COORD_W,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 desc_done,
  input  logic [DESC_BITS-1:0] desc_in,
  input  logic [COORD_W-1:0]   kp_x,
  input  logic [COORD_W-1:0]   kp_y,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_W-1:0]    m_data,
  output logic                 m_first,
  output logic                 m_last,
  output logic                 full,
  output logic                 overflow,
  input  logic                 clr_ovf,
  output rd_state_t            dbg_state
);

  localparam int ENTRY_W = DESC_BITS + 2 * COORD_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int NUM_DW  = DESC_BITS / WORD_W;
  localparam int SEL_W   = $clog2(NUM_DW);

  rd_state_t            state;
  rd_state_t            state_next;
  logic [IDX_W-1:0]     word_idx;
  logic [IDX_W-1:0]     word_idx_next;
  logic [ENTRY_W-1:0]   head;
  logic [CNT_W-1:0]     count;
  logic                 hs;
  logic                 pop;
  logic                 push;
  logic                 more_left;
  logic [WORD_W-1:0]    rec_word;
  logic [SEL_W-1:0]     body_sel;
  logic [DESC_BITS-1:0] head_desc;
  logic [2*COORD_W-1:0] head_yx;
  logic [WORD_W-1:0]    desc_words [NUM_DW];

  desc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({kp_y, kp_x, desc_in}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full)
  );

  assign hs   = m_valid && m_ready;
  assign pop  = hs && (word_idx == LAST_IDX);
  // A full FIFO still accepts when the head record leaves in the same cycle.
  assign push = desc_done && (!full || pop);
  // Entries left after popping the head: more than one now, or one arriving.
  assign more_left = (count > CNT_W'(1)) || push;

  always_comb begin
    state_next    = state;
    word_idx_next = word_idx;
    case (state)
      RD_IDLE: begin
        word_idx_next = '0;
        if (push) state_next = RD_HDR;
      end
      RD_HDR: begin
        if (hs) begin
          state_next    = RD_BODY;
          word_idx_next = IDX_W'(1);
        end
      end
      RD_BODY: begin
        if (hs) begin
          if (word_idx == LAST_IDX) begin
            word_idx_next = '0;
            state_next    = more_left ? RD_HDR : RD_IDLE;
          end else begin
            word_idx_next = word_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next    = RD_IDLE;
        word_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      word_idx <= '0;
    end else begin
      state    <= state_next;
      word_idx <= word_idx_next;
    end
  end

  // Clear loses to a drop in the same cycle so no dropped descriptor goes unnoticed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (desc_done && !push) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign head_desc = head[DESC_BITS-1:0];
  assign head_yx   = head[ENTRY_W-1 -: 2*COORD_W];
  assign body_sel  = SEL_W'(word_idx - IDX_W'(1));

  for (genvar g = 0; g < NUM_DW; g++) begin : g_words
    assign desc_words[g] = head_desc[g*WORD_W +: WORD_W];
  end

  always_comb begin
    rec_word = '0;
    if (word_idx == '0) begin
      rec_word[2*COORD_W-1:0] = head_yx;
    end else begin
      rec_word = desc_words[body_sel];
    end
  end

  // Gating with m_valid keeps unreset storage off the bus when empty.
  assign m_valid   = (state != RD_IDLE);
  assign m_data    = m_valid ? rec_word : '0;
  assign m_first   = m_valid && (word_idx == '0);
  assign m_last    = m_valid && (word_idx == LAST_IDX);
  assign dbg_state = state;

endmodule
